// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
//   state_t  : controller FSM encoding (2'd3 is unused and recovers to IDLE)
//   NIBBLE_W : width of the shared ripple adder slice
package serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
//   in_valid/in_ready   : operand request handshake (in_a, in_b, in_sub)
//   out_valid/out_ready : result handshake (out_sum, out_carry, out_overflow)
//   busy                : block is in RUN or DONE
// master = operand issuer / result consumer, slave = the adder controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_overflow, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_overflow, busy
  );

endinterface

// File: rtl/serial_adder_ctrl_nibble_adder.sv
// Combinational 4-bit ripple adder slice with carry-in.
//   a, b   : nibble operands
//   cin    : carry-in
//   sum    : nibble sum
//   cout   : carry-out
//   a_msb, b_msb : operand sign bits, used by the caller for signed overflow
module nibble_adder
  import serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                a_msb,
  output logic                b_msb
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  assign a_msb = a[NIBBLE_W-1];
  assign b_msb = b[NIBBLE_W-1];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer: reuses one 4-bit adder slice over
// WIDTH/4 cycles, least-significant nibble first.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of serial_adder_ctrl_if (operand and result
//                handshakes, busy)
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_adder_ctrl_if.slave    bus
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_cout;
  logic                nib_a_msb;
  logic                nib_b_msb;

  assign nib_a = a_q[cnt*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[cnt*NIBBLE_W +: NIBBLE_W];

  nibble_adder u_nibble_adder (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q),
    .sum   (nib_s),
    .cout  (nib_cout),
    .a_msb (nib_a_msb),
    .b_msb (nib_b_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // b is stored pre-inverted for subtract; the +1 comes from the initial carry.
  // out_sum is filled one nibble per RUN cycle and only qualified by out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_b ^ {WIDTH{bus.in_sub}};
      carry_q <= bus.in_sub;
      cnt     <= '0;
    end else if (state == RUN) begin
      sum_q[cnt*NIBBLE_W +: NIBBLE_W] <= nib_s;
      carry_q <= nib_cout;
      if (cnt == CNT_LAST) begin
        cout_q <= nib_cout;
        ovf_q  <= (nib_a_msb == nib_b_msb) && (nib_s[NIBBLE_W-1] != nib_b_msb);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.out_sum      = sum_q;
  assign bus.out_carry    = cout_q;
  assign bus.out_overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=16.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands in IDLE, takes the accepting edge, then scrambles the
  // inputs so a design that re-samples them would produce a wrong result.
  task automatic accept_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic sub);
    check({tag, "_in_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    step();
    bus.in_valid = 1'b0;
    bus.in_a     = 16'($urandom);
    bus.in_b     = 16'($urandom);
    bus.in_sub   = 1'($urandom);
    check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic await_result(input string tag, input logic [15:0] es, input logic ec,
                              input logic ev);
    int n = 0;
    bit rdy_seen = 1'b0;
    while (!bus.out_valid && n < 20) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_in_ready_run"}, 32'(rdy_seen), 32'd0);
    check({tag, "_sum"}, 32'(bus.out_sum), 32'(es));
    check({tag, "_carry"}, 32'(bus.out_carry), 32'(ec));
    check({tag, "_overflow"}, 32'(bus.out_overflow), 32'(ev));
    check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_result(input string tag, input logic [15:0] es);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum_held"}, 32'(bus.out_sum), 32'(es));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"add_plain",  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{"add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{"add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{"sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{"sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.out_sum), 32'd0);
    check("rst_carry", 32'(bus.out_carry), 32'd0);
    check("rst_overflow", 32'(bus.out_overflow), 32'd0);
    #11;
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      accept_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].sub);
      await_result(vecs[i].tag, vecs[i].s, vecs[i].c, vecs[i].v);
      release_result(vecs[i].tag, vecs[i].s);
    end

    // Backpressure: DONE must hold while requests are waved at it.
    accept_op("bp", 16'h1000, 16'h2000, 1'b0);
    await_result("bp", 16'h3000, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_a     = 16'($urandom);
      bus.in_b     = 16'($urandom);
      step();
      check("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready_hold", 32'(bus.in_ready), 32'd0);
      check("bp_sum_hold", 32'(bus.out_sum), 32'h3000);
      check("bp_carry_hold", 32'(bus.out_carry), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h0001;
    bus.in_b      = 16'h0002;
    bus.in_sub    = 1'b0;
    step();
    bus.out_ready = 1'b0;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    accept_op("b2b", 16'h0001, 16'h0002, 1'b0);
    await_result("b2b", 16'h0003, 1'b0, 1'b0);
    release_result("b2b", 16'h0003);

    // Reset during the second RUN cycle (low nibble already written).
    accept_op("mid_rst", 16'hAAAA, 16'h5555, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sum", 32'(bus.out_sum), 32'd0);
    check("mid_rst_carry", 32'(bus.out_carry), 32'd0);
    check("mid_rst_overflow", 32'(bus.out_overflow), 32'd0);
    step();
    check("mid_rst_held_valid", 32'(bus.out_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    accept_op("post_rst", 16'h1234, 16'h1111, 1'b0);
    await_result("post_rst", 16'h2345, 1'b0, 1'b0);
    release_result("post_rst", 16'h2345);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
